// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM generator with Avalon-MM register interface.
// Shared prescaler/period counter, per-channel duty/enable/polarity, shadowed updates at wrap.
module avalon_pwm_multi #(
    parameter int CHANNELS       = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq,
    output logic [CHANNELS-1:0] pwm_out
);

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    logic                      ctrl_en;
    logic                      ctrl_centre;
    logic                      ctrl_irq_en;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [CNT_WIDTH-1:0]      period_sh;
    logic [CNT_WIDTH-1:0]      period_act;
    logic [CHANNELS-1:0]       ch_en;
    logic [CHANNELS-1:0]       pol;
    logic                      wrap_flag;
    logic [CNT_WIDTH-1:0]      duty_sh  [CHANNELS];
    logic [CNT_WIDTH-1:0]      duty_act [CHANNELS];

    logic [PRESCALE_WIDTH-1:0] presc_cnt;
    logic [PRESCALE_WIDTH-1:0] presc_nxt;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [CNT_WIDTH-1:0]      cnt_nxt;
    dir_t                      dir;
    dir_t                      dir_nxt;
    logic                      tick;
    logic                      wrap;

    logic                      wr_ctrl;
    logic                      wr_prescale;
    logic                      wr_chen;
    logic                      wr_pol;
    logic                      wr_status;
    logic [CNT_WIDTH-1:0]      period_sh_nxt;
    logic [CNT_WIDTH-1:0]      duty_sh_nxt [CHANNELS];
    logic [31:0]               rd_mux;
    logic                      wdata_unused;

    assign wdata_unused = ^avs_writedata;

    assign wr_ctrl     = avs_write && (avs_address == 4'd0);
    assign wr_prescale = avs_write && (avs_address == 4'd1);
    assign wr_chen     = avs_write && (avs_address == 4'd3);
    assign wr_pol      = avs_write && (avs_address == 4'd4);
    assign wr_status   = avs_write && (avs_address == 4'd5);

    // Post-write shadow values; active registers load these so a write on the wrap cycle wins.
    always_comb begin
        period_sh_nxt = period_sh;
        if (avs_write && (avs_address == 4'd2))
            period_sh_nxt = avs_writedata[CNT_WIDTH-1:0];
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            duty_sh_nxt[i] = duty_sh[i];
            if (avs_write && (avs_address == 4'(8 + i)))
                duty_sh_nxt[i] = avs_writedata[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
            cnt       <= '0;
            dir       <= DIR_UP;
        end else begin
            presc_cnt <= presc_nxt;
            cnt       <= cnt_nxt;
            dir       <= dir_nxt;
        end
    end

    // Centre mode with PERIOD=0 falls back to edge counting.
    always_comb begin
        presc_nxt = presc_cnt;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        tick      = 1'b0;
        wrap      = 1'b0;
        if (!ctrl_en) begin
            presc_nxt = '0;
            cnt_nxt   = '0;
            dir_nxt   = DIR_UP;
        end else begin
            tick      = (presc_cnt >= prescale);
            presc_nxt = tick ? '0 : presc_cnt + 1'b1;
            if (tick) begin
                if (!ctrl_centre || (period_act == '0)) begin
                    dir_nxt = DIR_UP;
                    if (cnt >= period_act) begin
                        cnt_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if ((dir == DIR_UP) && (cnt < period_act)) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (cnt > 1) begin
                    cnt_nxt = cnt - 1'b1;
                    dir_nxt = DIR_DOWN;
                end else begin
                    cnt_nxt = '0;
                    dir_nxt = DIR_UP;
                    wrap    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_centre <= 1'b0;
            ctrl_irq_en <= 1'b0;
            prescale    <= '0;
            period_sh   <= '0;
            period_act  <= '0;
            ch_en       <= '0;
            pol         <= '0;
            wrap_flag   <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= avs_writedata[0];
                ctrl_centre <= avs_writedata[1];
                ctrl_irq_en <= avs_writedata[2];
            end
            if (wr_prescale)
                prescale <= avs_writedata[PRESCALE_WIDTH-1:0];
            if (wr_chen)
                ch_en <= avs_writedata[CHANNELS-1:0];
            if (wr_pol)
                pol <= avs_writedata[CHANNELS-1:0];
            period_sh <= period_sh_nxt;
            for (int unsigned i = 0; i < CHANNELS; i++)
                duty_sh[i] <= duty_sh_nxt[i];
            if (!ctrl_en || wrap) begin
                period_act <= period_sh_nxt;
                for (int unsigned i = 0; i < CHANNELS; i++)
                    duty_act[i] <= duty_sh_nxt[i];
            end
            if (wrap)
                wrap_flag <= 1'b1;
            else if (wr_status && avs_writedata[0])
                wrap_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++)
                pwm_out[i] <= (ch_en[i] && ctrl_en) ? ((cnt < duty_act[i]) ^ pol[i]) : pol[i];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            4'd0: rd_mux = {29'd0, ctrl_irq_en, ctrl_centre, ctrl_en};
            4'd1: rd_mux = 32'(prescale);
            4'd2: rd_mux = 32'(period_sh);
            4'd3: rd_mux = 32'(ch_en);
            4'd4: rd_mux = 32'(pol);
            4'd5: rd_mux = {31'd0, wrap_flag};
            4'd6: rd_mux = 32'(cnt);
            default: rd_mux = '0;
        endcase
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (avs_address == 4'(8 + i))
                rd_mux = 32'(duty_sh[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rd_mux;
    end

    assign irq = wrap_flag & ctrl_irq_en;

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Self-checking bench for avalon_pwm_multi: directed register/timing steps plus
// randomized configurations checked against an arithmetic period model.
module tb_avalon_pwm_multi;

    localparam int CH = 6;
    localparam int CW = 16;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic          irq;
    logic [CH-1:0] pwm_out;

    int n_assert = 0;
    int n_fail   = 0;

    avalon_pwm_multi #(
        .CHANNELS(CH),
        .CNT_WIDTH(CW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .irq(irq),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_write = 1'b1;
        avs_address = a;
        avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        avs_read = 1'b1;
        avs_address = a;
        @(negedge clk);
        avs_read = 1'b0;
        chk(tag, avs_readdata, exp);
    endtask

    // Reference model: counter value after k prescaler ticks since enable.
    function automatic int cnt_at(input int k, input int per, input bit centre);
        int m;
        if (!centre || per == 0)
            return k % (per + 1);
        m = k % (2 * per);
        return (m <= per) ? m : 2 * per - m;
    endfunction

    function automatic int plen(input int per, input bit centre);
        return (!centre || per == 0) ? per + 1 : 2 * per;
    endfunction

    function automatic logic [CH-1:0] exp_pwm(input int c, input int duty [CH],
                                              input logic [CH-1:0] chen, input logic [CH-1:0] pl);
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++)
            r[i] = chen[i] ? ((c < duty[i]) ^ pl[i]) : pl[i];
        return r;
    endfunction

    task automatic run_cfg(input bit centre, input int pr, input int per, input int duty [CH],
                           input logic [CH-1:0] chen, input logic [CH-1:0] pl, input bit irqen);
        int L;
        int n;
        wr(4'd0, 32'd0);
        wr(4'd1, pr);
        wr(4'd2, per);
        for (int i = 0; i < CH; i++)
            wr(4'(8 + i), duty[i]);
        wr(4'd3, 32'(chen));
        wr(4'd4, 32'(pl));
        wr(4'd5, 32'd1);
        chk("idle_pwm", 32'(pwm_out), 32'(pl));
        chk("idle_irq", 32'(irq), 32'd0);
        rd_chk(4'd5, 32'd0, "status_cleared");
        @(negedge clk);
        avs_write = 1'b1;
        avs_address = 4'd0;
        avs_writedata = {29'd0, irqen, centre, 1'b1};
        @(negedge clk);
        avs_write = 1'b0;
        chk("first_pwm", 32'(pwm_out), 32'(pl));
        avs_read = 1'b1;
        avs_address = 4'd6;
        L = plen(per, centre);
        n = 2 * L * (pr + 1) + 2;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            chk("count", avs_readdata, 32'(cnt_at((j - 1) / (pr + 1), per, centre)));
            chk("pwm", 32'(pwm_out), 32'(exp_pwm(cnt_at((j - 1) / (pr + 1), per, centre), duty, chen, pl)));
            chk("irq", 32'(irq), 32'(irqen && (j / (pr + 1) >= L)));
        end
        avs_read = 1'b0;
    endtask

    bit            c_centre;
    int            c_pr;
    int            c_per;
    int            c_duty [CH];
    logic [CH-1:0] c_chen;
    logic [CH-1:0] c_pol;
    bit            c_irq;
    int            d;
    logic [31:0]   held;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++)
            rd_chk(4'(a), 32'd0, "rst_reg");

        // Register widths, unmapped addresses, read hold
        wr(4'd2, 32'hFFFF_0009);
        rd_chk(4'd2, 32'h0000_0009, "period_trunc");
        wr(4'd3, 32'hFFFF_FFFF);
        rd_chk(4'd3, 32'h0000_003F, "chen_trunc");
        wr(4'd1, 32'hABCD_0003);
        rd_chk(4'd1, 32'h0000_0003, "prescale_trunc");
        wr(4'd13, 32'h0001_0007);
        rd_chk(4'd13, 32'h0000_0007, "duty5_trunc");
        wr(4'd14, 32'd1234);
        rd_chk(4'd14, 32'd0, "duty_oob");
        rd_chk(4'd7, 32'd0, "unmapped7");
        wr(4'd0, 32'hFFFF_FFF8);
        rd_chk(4'd0, 32'd0, "ctrl_high_bits");
        held = avs_readdata;
        rd_chk(4'd13, 32'h0000_0007, "duty5_again");
        @(negedge clk);
        @(negedge clk);
        chk("rdata_hold", avs_readdata, 32'h0000_0007);

        // Fixed configurations from the plan, then random ones
        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < CH; i++)
                c_duty[i] = 0;
            if (t == 0) begin
                c_centre = 0; c_pr = 0; c_per = 9; c_duty[0] = 3; c_chen = 6'h01; c_pol = 6'h00; c_irq = 1;
            end else if (t == 1) begin
                c_centre = 0; c_pr = 1; c_per = 3; c_duty[1] = 2; c_chen = 6'h02; c_pol = 6'h02; c_irq = 0;
            end else if (t == 2) begin
                c_centre = 1; c_pr = 0; c_per = 4; c_duty[0] = 2; c_chen = 6'h01; c_pol = 6'h00; c_irq = 1;
            end else begin
                c_centre = 1'($urandom_range(0, 1));
                c_pr     = int'($urandom_range(0, 3));
                c_per    = int'($urandom_range(0, 12));
                for (int i = 0; i < CH; i++)
                    c_duty[i] = int'($urandom_range(0, c_per + 2));
                c_chen = CH'($urandom);
                c_pol  = CH'($urandom);
                c_irq  = 1'($urandom_range(0, 1));
            end
            run_cfg(c_centre, c_pr, c_per, c_duty, c_chen, c_pol, c_irq);
        end

        // Shadowed duty change, write-on-wrap, W1C races, disable mid-period
        wr(4'd0, 32'd0);
        wr(4'd1, 32'd0);
        wr(4'd2, 32'd9);
        wr(4'd8, 32'd3);
        for (int i = 1; i < CH; i++)
            wr(4'(8 + i), 32'd0);
        wr(4'd3, 32'd1);
        wr(4'd4, 32'd0);
        wr(4'd5, 32'd1);
        @(negedge clk);
        avs_write = 1'b1;
        avs_address = 4'd0;
        avs_writedata = 32'd5;
        @(negedge clk);
        avs_write = 1'b0;
        chk("dir_pwm0", 32'(pwm_out), 32'd0);
        for (int j = 1; j <= 36; j++) begin
            @(negedge clk);
            avs_write = 1'b0;
            d = (j <= 10) ? 3 : (j <= 20) ? 7 : 5;
            chk("dir_pwm", 32'(pwm_out), 32'((j <= 33) && (((j - 1) % 10) < d)));
            chk("dir_irq", 32'(irq), 32'((j < 33) && (((j >= 10) && (j < 15)) || (j >= 20))));
            case (j + 1)
                5:  begin avs_write = 1'b1; avs_address = 4'd8; avs_writedata = 32'd7; end
                15: begin avs_write = 1'b1; avs_address = 4'd5; avs_writedata = 32'd1; end
                20: begin avs_write = 1'b1; avs_address = 4'd8; avs_writedata = 32'd5; end
                30: begin avs_write = 1'b1; avs_address = 4'd5; avs_writedata = 32'd1; end
                33: begin avs_write = 1'b1; avs_address = 4'd0; avs_writedata = 32'd0; end
                default: ;
            endcase
        end
        rd_chk(4'd6, 32'd0, "count_after_disable");
        rd_chk(4'd5, 32'd1, "flag_set_wins");

        // Asynchronous reset mid-period
        wr(4'd0, 32'd5);
        @(negedge clk);
        chk("pre_rst_pwm", 32'(pwm_out), 32'd1);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_pwm", 32'(pwm_out), 32'd0);
        chk("async_irq", 32'(irq), 32'd0);
        chk("async_rdata", avs_readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++)
            rd_chk(4'(a), 32'd0, "post_rst_reg");
        chk("post_rst_pwm", 32'(pwm_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
